hwpe_ownership_scheduler: RTL

//  Arbitrates exclusive ownership of the clustered HWPE subsystem among N_CORES cores.

---
 rtl/hwpe_ownership_scheduler_if.sv | 26 ++
 rtl/hwpe_ownership_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hwpe_ownership_scheduler_if.sv
// Request/grant and HWPE-control signals between the cores, the ownership
// scheduler and the clustered HWPE subsystem.
interface hwpe_ownership_scheduler_if #(
  parameter int N_CORES = 8,
  parameter int SEL_W   = 2
);
  logic [N_CORES-1:0]       req_i;
  logic [N_CORES*SEL_W-1:0] req_hwpe_i;
  logic [N_CORES-1:0]       release_i;
  logic [N_CORES-1:0]       gnt_o;
  logic [N_CORES-1:0]       owner_o;
  logic                     hwpe_busy_i;
  logic                     hwpe_en_o;
  logic [SEL_W-1:0]         hwpe_sel_o;
  logic                     err_o;

  modport master (
    output req_i, req_hwpe_i, release_i, hwpe_busy_i,
    input  gnt_o, owner_o, hwpe_en_o, hwpe_sel_o, err_o
  );

  modport slave (
    input  req_i, req_hwpe_i, release_i, hwpe_busy_i,
    output gnt_o, owner_o, hwpe_en_o, hwpe_sel_o, err_o
  );
endinterface

// File: rtl/hwpe_ownership_scheduler.sv
// Round-robin ownership arbiter for the clustered HWPE subsystem; sequences
// clock gating around every HWPE select change and drains before re-arbitrating.
module hwpe_ownership_scheduler #(
  parameter int N_CORES       = 8,
  parameter int N_HWPES       = 3,
  parameter int SEL_W         = (N_HWPES > 1) ? $clog2(N_HWPES) : 1,
  parameter int SWITCH_CYCLES = 2
) (
  input logic                       clk,
  input logic                       rst,
  hwpe_ownership_scheduler_if.slave bus
);
  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CNT_W = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [SEL_W:0]   N_HWPES_W = (SEL_W+1)'(N_HWPES);
  localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(N_CORES - 1);

  typedef enum logic [2:0] {IDLE, GATE, ENABLE, OWNED, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic [N_CORES-1:0] valid;
  logic [N_CORES-1:0] elig;
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [SEL_W-1:0]   win_hwpe;
  logic [N_CORES-1:0] win_onehot;

  always_comb begin
    valid = '0;
    for (int unsigned c = 0; c < N_CORES; c++) begin
      valid[c] = {1'b0, bus.req_hwpe_i[c*SEL_W +: SEL_W]} < N_HWPES_W;
    end
  end

  assign elig = bus.req_i & valid;

  // First eligible core at or above the pointer, wrapping around.
  always_comb begin : arb
    int unsigned cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      cand = (32'(rr_q) + i) % 32'(N_CORES);
      if (!arb_found && elig[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_hwpe   = bus.req_hwpe_i[arb_idx*SEL_W +: SEL_W];
  assign win_onehot = N_CORES'(1) << win_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          win_d = arb_idx;
          rr_d  = (arb_idx == LAST_CORE) ? '0 : arb_idx + IDX_W'(1);
          if (win_hwpe == sel_q) begin
            state_d = ENABLE;
          end else begin
            state_d = GATE;
            sel_d   = win_hwpe;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      GATE: begin
        if (cnt_q == '0) state_d = ENABLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      // A release coinciding with the grant cycle goes straight to DRAIN.
      ENABLE, OWNED: begin
        state_d = bus.release_i[win_q] ? DRAIN : OWNED;
      end
      DRAIN: begin
        if (!bus.hwpe_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.hwpe_en_o  = 1'b0;
    bus.gnt_o      = '0;
    bus.owner_o    = '0;
    bus.hwpe_sel_o = sel_q;
    bus.err_o      = |(bus.req_i & ~valid);
    unique case (state_q)
      ENABLE: begin
        bus.hwpe_en_o = 1'b1;
        bus.gnt_o     = win_onehot;
        bus.owner_o   = win_onehot;
      end
      OWNED, DRAIN: begin
        bus.hwpe_en_o = 1'b1;
        bus.owner_o   = win_onehot;
      end
      default: ;
    endcase
  end
endmodule
